ex_div_unit: RTL and testbench

//  Multi-cycle 32-bit DIV/DIVU engine in the EX stage, directly upstream of the stall controller.

---
 rtl/ex_div_unit_pkg.sv | 12 +
 rtl/ex_div_unit_div_step.sv | 24 ++
 rtl/ex_div_unit.sv | 119 +++++++++++
 tb/tb_ex_div_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the EX-stage multi-cycle divider.
package ex_div_unit_pkg;

    localparam int unsigned DivWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One restoring-division iteration on a {remainder, quotient} partial register.
module ex_div_unit_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH:0]  partial_i,
    input  logic [WIDTH-1:0]  divisor_i,
    output logic [2*WIDTH:0]  partial_o
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted   = partial_i << 1;
        trial     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor_i};
        partial_o = shifted;
        // MSB of trial is the borrow: set means the divisor did not fit.
        if (!trial[WIDTH+1]) begin
            partial_o[2*WIDTH:WIDTH] = trial[WIDTH:0];
            partial_o[0]             = 1'b1;
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle DIV/DIVU engine for the EX stage: one restoring step per cycle,
// sign handled by magnitude division plus a final fix-up.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_e         state_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH:0]   partial_q;
    logic [WIDTH-1:0]   divisor_q;
    logic               neg_quot_q;
    logic               neg_rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [2*WIDTH:0]   partial_next;
    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               unused_partial_top;

    ex_div_unit_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .partial_i (partial_q),
        .divisor_i (divisor_q),
        .partial_o (partial_next)
    );

    // The remainder always fits in WIDTH bits, so the extra partial bit is dropped.
    assign unused_partial_top = partial_next[2*WIDTH];

    always_comb begin
        op1_neg  = signed_i & opdata1_i[WIDTH-1];
        op2_neg  = signed_i & opdata2_i[WIDTH-1];
        op1_abs  = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_abs  = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
        quot_fix = neg_quot_q ? (~partial_next[WIDTH-1:0] + 1'b1) : partial_next[WIDTH-1:0];
        rem_fix  = neg_rem_q ? (~partial_next[2*WIDTH-1:WIDTH] + 1'b1)
                             : partial_next[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            partial_q  <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (annul_i) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            if (opdata2_i == '0) begin
                                // Divide-by-zero: raw dividend as remainder, all-ones quotient.
                                result_q <= {opdata1_i, {WIDTH{1'b1}}};
                                ready_q  <= 1'b1;
                                state_q  <= StDone;
                            end else begin
                                partial_q  <= {{(WIDTH + 1){1'b0}}, op1_abs};
                                divisor_q  <= op2_abs;
                                neg_quot_q <= op1_neg ^ op2_neg;
                                neg_rem_q  <= op1_neg;
                                cnt_q      <= '0;
                                state_q    <= StCalc;
                            end
                        end
                    end
                    StCalc: begin
                        partial_q <= partial_next;
                        cnt_q     <= cnt_q + CntW'(1);
                        if (cnt_q == CntW'(WIDTH - 1)) begin
                            result_q <= {rem_fix, quot_fix};
                            ready_q  <= 1'b1;
                            state_q  <= StDone;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: arithmetic reference model with per-cycle compare,
// directed literal cases and randomized divides.
module tb_ex_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          cyc    = 0;
    bit          m_pend = 1'b0;
    bit          m_rdy  = 1'b0;
    int          m_due  = 0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_out  = '0;

    int          last_ready_cyc;
    logic        last_stall;

    ex_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: accepted divide shows ready 33 cycles later (1 for divide-by-zero); annul wins.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend <= 1'b0;
            m_rdy  <= 1'b0;
            m_out  <= '0;
        end else begin
            if (m_pend && !start_i && !annul_i) $error("illegal start_i drop during divide");
            cyc   <= cyc + 1;
            m_rdy <= 1'b0;
            if (annul_i) begin
                m_pend <= 1'b0;
            end else if (m_pend) begin
                if (cyc == m_due) begin
                    m_rdy  <= 1'b1;
                    m_out  <= m_res;
                    m_pend <= 1'b0;
                end
            end else if (!m_rdy && start_i) begin
                if (opdata2_i == 32'd0) begin
                    m_rdy <= 1'b1;
                    m_out <= ref_div(signed_i, opdata1_i, opdata2_i);
                end else begin
                    m_res  <= ref_div(signed_i, opdata1_i, opdata2_i);
                    m_pend <= 1'b1;
                    m_due  <= cyc + 32;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ready_o", {63'd0, ready_o}, {63'd0, m_rdy});
        check("result_o", result_o, m_out);
        check("stallreq_o", {63'd0, stallreq_o}, {63'd0, start_i & ~m_rdy});
    end

    // Drives one divide from an EX-stage view; lat = cycle of ready_o, -1 if annulled.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int annul_at, output logic [63:0] res, output int lat);
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        annul_i   = (annul_at == 0);
        lat       = -1;
        res       = '0;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (ready_o) begin
                lat            = n;
                res            = result_o;
                last_ready_cyc = cyc;
                last_stall     = stallreq_o;
                break;
            end
            @(posedge clk);
            #1;
            if (annul_i) begin
                annul_i = 1'b0;
                start_i = 1'b0;
                break;
            end
            annul_i   = (n + 1 == annul_at);
            opdata1_i = $urandom;
            opdata2_i = $urandom;
        end
        if (lat >= 0) begin
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        if (annul_at < 0 && lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no ready_o within 40 cycles, expected one");
        end
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] res2;
        int          lat;
        int          lat2;
        int          t0;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          an;

        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        #3 rst = 1'b0;
        #9;
        check("reset result_o", result_o, 64'd0);
        check("reset ready_o", {63'd0, ready_o}, 64'd0);
        check("reset stallreq_o", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Pin the reference model itself.
        check("ref DIV -7/2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("ref DIVU 0xFFFFFFF9/2", ref_div(1'b0, 32'hFFFF_FFF9, 32'd2),
              {32'd1, 32'h7FFF_FFFC});
        check("ref DIV 7/-2", ref_div(1'b1, 32'd7, 32'hFFFF_FFFE), {32'd1, 32'hFFFF_FFFD});

        run_div(1'b0, 32'd100, 32'd7, -1, res, lat);
        check("DIVU 100/7 result", res, {32'd2, 32'd14});
        check("DIVU 100/7 latency", 64'(lat), 64'd33);
        check("DIVU 100/7 stall in ready cycle", {63'd0, last_stall}, 64'd0);

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, res, lat);
        check("DIV -7/2 result", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, -1, res, lat);
        check("DIVU 0xFFFFFFF9/2 result", res, {32'd1, 32'h7FFF_FFFC});

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, res, lat);
        check("DIV overflow result", res, {32'd0, 32'h8000_0000});

        run_div(1'b0, 32'd5, 32'd0, -1, res, lat);
        check("DIVU 5/0 result", res, {32'd5, 32'hFFFF_FFFF});
        check("DIVU 5/0 latency", 64'(lat), 64'd1);

        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, -1, res, lat);
        check("DIV -5/0 result", res, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

        run_div(1'b0, 32'd1000, 32'd3, 10, res, lat);
        check("annul no ready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        run_div(1'b0, 32'd9, 32'd3, -1, res, lat);
        check("DIVU 9/3 after annul result", res, {32'd0, 32'd3});
        check("DIVU 9/3 after annul latency", 64'(lat), 64'd33);

        run_div(1'b0, 32'd20, 32'd6, -1, res, lat);
        t0 = last_ready_cyc;
        run_div(1'b0, 32'd8, 32'd8, -1, res2, lat2);
        check("b2b first result", res, {32'd2, 32'd3});
        check("b2b second result", res2, {32'd0, 32'd1});
        check("b2b pulse spacing", 64'(last_ready_cyc - t0), 64'd34);

        // Asynchronous reset in the middle of a divide.
        signed_i  = 1'b0;
        opdata1_i = 32'd1234;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("async reset result_o", result_o, 64'd0);
        check("async reset ready_o", {63'd0, ready_o}, 64'd0);
        check("async reset stallreq_o", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_div(1'b0, 32'd77, 32'd7, -1, res, lat);
        check("post-reset DIVU 77/7 result", res, {32'd0, 32'd11});
        check("post-reset DIVU 77/7 latency", 64'(lat), 64'd33);

        for (int i = 0; i < 25; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin
                    a   = 32'h8000_0000;
                    b   = 32'hFFFF_FFFF;
                    sgn = 1'b1;
                end
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            an = -1;
            if ($urandom_range(0, 5) == 0) an = (b == 32'd0) ? 0 : int'($urandom_range(0, 32));
            run_div(sgn, a, b, an, res, lat);
            if (an < 0) check("random result", res, ref_div(sgn, a, b));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
